// File: rtl/time_counter.sv
// time_counter: time-of-day clock driven by the pseudo-PLL square wave.
// Synchronises pll_clk, detects its rising edges, prescales them into
// one-second advances and keeps a 24-hour BCD HH:MM:SS time with a
// validated synchronous load port.
module time_counter #(
    parameter int SYNC_STAGES   = 2,
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       pll_clk,
    input  logic       enable,
    input  logic       load,
    input  logic [5:0] hours_in,
    input  logic [6:0] min_in,
    input  logic [6:0] sec_in,
    output logic [5:0] hours,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic       sec_tick,
    output logic       load_err
);

    localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [7:0]             presc_q, presc_d;
    logic [5:0]             hours_q, hours_d;
    logic [6:0]             min_q, min_d;
    logic [6:0]             sec_q, sec_d;
    logic                   sec_tick_q, sec_tick_d;
    logic                   load_err_q, load_err_d;
    logic                   pll_rise;
    logic [19:0]            next_time;

    // One-second BCD advance with seconds -> minutes -> hours carries;
    // 23:59:59 rolls over to 00:00:00.
    function automatic logic [19:0] bcd_advance(input logic [5:0] h,
                                                input logic [6:0] m,
                                                input logic [6:0] s);
        logic [5:0] h_n;
        logic [6:0] m_n;
        logic [6:0] s_n;
        logic       s_wrap;
        logic       m_wrap;
        s_wrap = (s == 7'h59);
        m_wrap = s_wrap && (m == 7'h59);
        if (s_wrap)
            s_n = 7'h00;
        else if (s[3:0] == 4'd9)
            s_n = {s[6:4] + 3'd1, 4'd0};
        else
            s_n = {s[6:4], s[3:0] + 4'd1};
        m_n = m;
        if (s_wrap) begin
            if (m_wrap)
                m_n = 7'h00;
            else if (m[3:0] == 4'd9)
                m_n = {m[6:4] + 3'd1, 4'd0};
            else
                m_n = {m[6:4], m[3:0] + 4'd1};
        end
        h_n = h;
        if (m_wrap) begin
            if (h == 6'h23)
                h_n = 6'h00;
            else if (h[3:0] == 4'd9)
                h_n = {h[5:4] + 2'd1, 4'd0};
            else
                h_n = {h[5:4], h[3:0] + 4'd1};
        end
        return {h_n, m_n, s_n};
    endfunction

    // A load is accepted only if every field is a legal BCD time of day.
    function automatic logic load_valid(input logic [5:0] h,
                                        input logic [6:0] m,
                                        input logic [6:0] s);
        logic ok;
        ok = (h[3:0] <= 4'd9) && (m[3:0] <= 4'd9) && (s[3:0] <= 4'd9);
        ok = ok && (m[6:4] <= 3'd5) && (s[6:4] <= 3'd5);
        ok = ok && (h[5:4] <= 2'd2);
        ok = ok && ((h[5:4] != 2'd2) || (h[3:0] <= 4'd3));
        return ok;
    endfunction

    // Next-state logic: synchroniser shift, then load beats a counted edge.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], pll_clk};
        prev_d     = sync_q[SYNC_STAGES-1];
        pll_rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
        next_time  = bcd_advance(hours_q, min_q, sec_q);
        presc_d    = presc_q;
        hours_d    = hours_q;
        min_d      = min_q;
        sec_d      = sec_q;
        sec_tick_d = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            // Any load swallows a coincident edge; only a valid one clears the prescaler.
            if (load_valid(hours_in, min_in, sec_in)) begin
                hours_d = hours_in;
                min_d   = min_in;
                sec_d   = sec_in;
                presc_d = 8'd0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (pll_rise && enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d    = 8'd0;
                hours_d    = next_time[19:14];
                min_d      = next_time[13:7];
                sec_d      = next_time[6:0];
                sec_tick_d = 1'b1;
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end
    end

    // State registers; the synchroniser resets high so a wave already high
    // at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q     <= '1;
            prev_q     <= 1'b1;
            presc_q    <= 8'd0;
            hours_q    <= 6'h00;
            min_q      <= 7'h00;
            sec_q      <= 7'h00;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            presc_q    <= presc_d;
            hours_q    <= hours_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            sec_tick_q <= sec_tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign hours    = hours_q;
    assign minutes  = min_q;
    assign seconds  = sec_q;
    assign sec_tick = sec_tick_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: two instances (1 and 4 edges per second) share
// stimulus and are compared every cycle with a seconds-of-day model, plus
// a table of loads and hand-written corner-case sequences.
module tb_time_counter;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset, pll_clk, enable, load;
    logic [5:0] hours_in;
    logic [6:0] min_in, sec_in;
    logic [5:0] h1, h4;
    logic [6:0] mi1, mi4, s1, s4;
    logic       tick1, tick4, err1, err4;

    int total = 0;
    int bad   = 0;

    time_counter #(.SYNC_STAGES(S), .TICKS_PER_SEC(1)) dut1 (
        .clk_in(clk), .reset(reset), .pll_clk(pll_clk), .enable(enable), .load(load),
        .hours_in(hours_in), .min_in(min_in), .sec_in(sec_in),
        .hours(h1), .minutes(mi1), .seconds(s1), .sec_tick(tick1), .load_err(err1));

    time_counter #(.SYNC_STAGES(S), .TICKS_PER_SEC(4)) dut4 (
        .clk_in(clk), .reset(reset), .pll_clk(pll_clk), .enable(enable), .load(load),
        .hours_in(hours_in), .min_in(min_in), .sec_in(sec_in),
        .hours(h4), .minutes(mi4), .seconds(s4), .sec_tick(tick4), .load_err(err4));

    always #5 clk = ~clk;

    // Reference model: time as seconds since midnight, per instance.
    int m_t[2];
    int m_pre[2];
    int tps[2] = '{1, 4};
    bit m_tick[2];
    bit m_err;
    bit hist[S+2];   // hist[j] = pll_clk level sampled j clock edges ago

    typedef struct {
        logic [5:0] h;
        logic [6:0] m;
        logic [6:0] s;
        logic       err;
        logic [5:0] eh;
        logic [6:0] em;
        logic [6:0] es;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int from_bcd(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic bit time_ok(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s);
        if (h[3:0] > 9 || m[3:0] > 9 || s[3:0] > 9) return 1'b0;
        return from_bcd({2'b0, h}) <= 23 && from_bcd({1'b0, m}) <= 59 && from_bcd({1'b0, s}) <= 59;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_t[d] = 0; m_pre[d] = 0; m_tick[d] = 1'b0;
        end
        m_err = 1'b0;
        for (int j = 0; j < S + 2; j++) hist[j] = 1'b1;
    endtask

    // Applied at each rising clock edge with the inputs present at that edge.
    task automatic model_update();
        bit due;
        if (reset) begin
            model_reset();
            return;
        end
        for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = pll_clk;
        due = hist[S] && !hist[S+1];
        m_err = 1'b0;
        for (int d = 0; d < 2; d++) m_tick[d] = 1'b0;
        if (load) begin
            if (time_ok(hours_in, min_in, sec_in)) begin
                for (int d = 0; d < 2; d++) begin
                    m_t[d] = from_bcd({2'b0, hours_in}) * 3600 + from_bcd({1'b0, min_in}) * 60
                             + from_bcd({1'b0, sec_in});
                    m_pre[d] = 0;
                end
            end else begin
                m_err = 1'b1;
            end
        end else if (due && enable) begin
            for (int d = 0; d < 2; d++) begin
                if (m_pre[d] == tps[d] - 1) begin
                    m_pre[d]  = 0;
                    m_t[d]    = (m_t[d] + 1) % 86400;
                    m_tick[d] = 1'b1;
                end else begin
                    m_pre[d]++;
                end
            end
        end
    endtask

    task automatic check_model();
        check("dut1 hours",   h1,    to_bcd(m_t[0] / 3600));
        check("dut1 minutes", mi1,   to_bcd((m_t[0] / 60) % 60));
        check("dut1 seconds", s1,    to_bcd(m_t[0] % 60));
        check("dut1 tick",    tick1, m_tick[0]);
        check("dut1 err",     err1,  m_err);
        check("dut4 hours",   h4,    to_bcd(m_t[1] / 3600));
        check("dut4 minutes", mi4,   to_bcd((m_t[1] / 60) % 60));
        check("dut4 seconds", s4,    to_bcd(m_t[1] % 60));
        check("dut4 tick",    tick4, m_tick[1]);
        check("dut4 err",     err4,  m_err);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_load(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s);
        hours_in = h; min_in = m; sec_in = s; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic edge_pulse();
        pll_clk = 1'b0;
        repeat (4) cyc();
        pll_clk = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic check_zero_now(input string nm);
        check({nm, " hours"},   h1,    0);
        check({nm, " minutes"}, mi1,   0);
        check({nm, " seconds"}, s1,    0);
        check({nm, " tick"},    tick1, 0);
        check({nm, " err"},     err1,  0);
    endtask

    initial begin
        tbl[0] = '{6'h23, 7'h59, 7'h58, 1'b0, 6'h23, 7'h59, 7'h59};
        tbl[1] = '{6'h23, 7'h59, 7'h59, 1'b0, 6'h00, 7'h00, 7'h00};
        tbl[2] = '{6'h09, 7'h09, 7'h59, 1'b0, 6'h09, 7'h10, 7'h00};
        tbl[3] = '{6'h19, 7'h59, 7'h59, 1'b0, 6'h20, 7'h00, 7'h00};
        tbl[4] = '{6'h24, 7'h00, 7'h00, 1'b1, 6'h12, 7'h00, 7'h01};
        tbl[5] = '{6'h12, 7'h60, 7'h00, 1'b1, 6'h12, 7'h00, 7'h01};
        tbl[6] = '{6'h12, 7'h00, 7'h0A, 1'b1, 6'h12, 7'h00, 7'h01};
        tbl[7] = '{6'h1A, 7'h00, 7'h00, 1'b1, 6'h12, 7'h00, 7'h01};
        tbl[8] = '{6'h30, 7'h00, 7'h00, 1'b1, 6'h12, 7'h00, 7'h01};
        tbl[9] = '{6'h00, 7'h00, 7'h00, 1'b0, 6'h00, 7'h00, 7'h01};

        reset = 1'b1; pll_clk = 1'b1; enable = 1'b1; load = 1'b0;
        hours_in = '0; min_in = '0; sec_in = '0;
        model_reset();
        #1;
        check_zero_now("reset");
        repeat (2) cyc();
        reset = 1'b0;

        // pll_clk high through reset release: no edge until a low is seen.
        repeat (10) cyc();
        check("held-high seconds", s1, 0);
        pll_clk = 1'b0;
        repeat (3) cyc();
        pll_clk = 1'b1;
        repeat (S) cyc();
        check("before first advance", s1, 0);
        cyc();
        check("first advance seconds", s1, 7'h01);
        check("first advance tick", tick1, 1);
        cyc();
        check("tick one cycle wide", tick1, 0);

        // Table of loads, each followed by one edge.
        for (int i = 0; i < 10; i++) begin
            do_load(6'h12, 7'h00, 7'h00);
            hours_in = tbl[i].h; min_in = tbl[i].m; sec_in = tbl[i].s; load = 1'b1;
            cyc();
            load = 1'b0;
            check("tbl load_err", err1, tbl[i].err);
            check("tbl load tick", tick1, 0);
            cyc();
            check("tbl load_err width", err1, 0);
            pll_clk = 1'b0;
            repeat (4) cyc();
            pll_clk = 1'b1;
            repeat (S + 1) cyc();
            check("tbl hours", h1, tbl[i].eh);
            check("tbl minutes", mi1, tbl[i].em);
            check("tbl seconds", s1, tbl[i].es);
            check("tbl tick", tick1, 1);
            repeat (2) cyc();
        end

        // Midnight rollover over two consecutive advances.
        do_load(6'h23, 7'h59, 7'h58);
        edge_pulse();
        check("roll1", {h1, mi1, s1}, {6'h23, 7'h59, 7'h59});
        edge_pulse();
        check("roll2", {h1, mi1, s1}, {6'h00, 7'h00, 7'h00});

        // Prescaler of 4, enable gating, and a load coincident with an edge.
        do_load(6'h00, 7'h00, 7'h00);
        repeat (3) edge_pulse();
        check("tps4 three edges", s4, 0);
        check("tps1 three edges", s1, 7'h03);
        enable = 1'b0;
        repeat (2) edge_pulse();
        enable = 1'b1;
        repeat (2) cyc();
        check("tps4 disabled", s4, 0);
        edge_pulse();
        check("tps4 fourth edge", s4, 7'h01);
        check("tps1 after enable", s1, 7'h04);
        pll_clk = 1'b0;
        repeat (4) cyc();
        pll_clk = 1'b1;
        repeat (S) cyc();
        do_load(6'h10, 7'h20, 7'h30);
        check("coincident load kept", {h1, mi1, s1}, {6'h10, 7'h20, 7'h30});
        check("coincident load no tick", tick1, 0);
        repeat (3) cyc();
        check("coincident edge dropped", s1, 7'h30);
        repeat (3) edge_pulse();
        check("tps4 prescaler cleared", s4, 7'h30);
        edge_pulse();
        check("tps4 after clear", s4, 7'h31);

        // Reset while an edge is inside the synchroniser.
        do_load(6'h12, 7'h34, 7'h56);
        pll_clk = 1'b0;
        repeat (4) cyc();
        pll_clk = 1'b1;
        cyc();
        reset = 1'b1;
        #1;
        check_zero_now("mid reset");
        model_reset();
        cyc();
        reset = 1'b0;
        repeat (6) cyc();
        check("no in-flight tick", s1, 0);

        // Randomised traffic against the model.
        begin
            int ph;
            ph = 3;
            for (int n = 0; n < 4000; n++) begin
                ph--;
                if (ph == 0) begin
                    pll_clk = ~pll_clk;
                    ph = $urandom_range(3, 8);
                end
                enable = ($urandom_range(0, 7) != 0);
                reset  = ($urandom_range(0, 599) == 0);
                load   = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 1) == 0) begin
                    hours_in = 6'(to_bcd($urandom_range(0, 23)));
                    min_in   = 7'(to_bcd($urandom_range(0, 59)));
                    sec_in   = 7'(to_bcd($urandom_range(0, 59)));
                end else begin
                    hours_in = 6'($urandom);
                    min_in   = 7'($urandom);
                    sec_in   = 7'($urandom);
                end
                cyc();
            end
            reset = 1'b0;
            load  = 1'b0;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/time_counter.md
# time_counter

Time-of-day counter that consumes the slow square wave produced by the pseudo-PLL stage. It synchronises that wave into the system clock domain and detects its rising edges. It prescales those edges into one-second ticks and maintains a 24-hour BCD time (HH:MM:SS) with a validated synchronous load port. It sits directly downstream of the pseudo-PLL and feeds the display/alarm logic.

## Interface
- SYNC_STAGES, 2: number of synchroniser flops on pll_clk (minimum 2).
- TICKS_PER_SEC, 1: pll_clk rising edges per one-second advance (1..255).

Ports (reset is asynchronous, active-high; one clock):
- clk_in  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pll_clk  input  1  pseudo-PLL output; asynchronous to clk_in, high and low phases each at least SYNC_STAGES+1 clk_in cycles.
- enable  input  1  1 = count edges; 0 = ignore edges, hold prescaler and time.
- load  input  1  one-cycle request to load hours_in/min_in/sec_in.
- hours_in  input  6  BCD {tens[5:4], units[3:0]}.
- min_in  input  7  BCD {tens[6:4], units[3:0]}.
- sec_in  input  7  BCD {tens[6:4], units[3:0]}.
- hours  output  6  current hours, BCD, 00..23.
- minutes  output  7  current minutes, BCD, 00..59.
- seconds  output  7  current seconds, BCD, 00..59.
- sec_tick  output  1  one-cycle pulse, high in the cycle in which a newly advanced time is first visible.
- load_err  output  1  one-cycle pulse, high in the cycle after a rejected load.

## Operation
- Synchroniser: SYNC_STAGES flops, then a "prev" flop. All of them reset to 1. edge = sync_last & ~prev.
- Because the chain resets to 1, a pll_clk that is already high at reset release produces no edge. The first counted edge requires pll_clk to be sampled low at least once.
- Prescaler: 8-bit count, reset 0.
  - On edge with enable=1: if count == TICKS_PER_SEC-1, then count := 0 and the time advances. Otherwise count += 1.
- Advance cascade, BCD:
  - sec units 9→0 carries into sec tens.
  - sec tens 5 with units 9 → seconds 00, carry into minutes (same rules).
  - minutes 59 carry → hours.
  - hours 23:59:59 → 00:00:00. hours units wrap 9→0 into tens, except at 23, which wraps to 00.
- Load validation. A load is valid iff:
  - every units digit ≤ 9;
  - sec/min tens ≤ 5;
  - hours tens ≤ 2, and hours ≤ 23 when tens = 2.
- Valid load: time := inputs, prescaler := 0, sec_tick not asserted. Applied even when enable=0.
- Invalid load: time and prescaler unchanged; load_err = 1 for exactly one cycle, on the next cycle.
- Priority: reset > load > tick. A load (valid or invalid) in the same cycle as a qualifying edge discards that edge. The prescaler is not incremented, and it is cleared only on a valid load.
- enable=0: the synchroniser and prev keep running, so re-enabling mid-high-phase produces no spurious edge. Edges during enable=0 are lost, not queued.
- Reset (any time, including mid-cascade): hours/minutes/seconds = 0, sec_tick = 0, load_err = 0, prescaler = 0, synchroniser and prev = 1.

## Timing
- pll_clk rise first sampled at clk_in edge k:
  - edge is high during the cycle after edge k+SYNC_STAGES-1;
  - the time/prescaler update at edge k+SYNC_STAGES;
  - sec_tick is high for the cycle following that edge.
- Load latency: load high at edge n gives the new time visible after edge n. load_err (if invalid) is high between edges n and n+1.
- sec_tick and load_err are registered, never asserted simultaneously, and each at most one cycle wide.
- Outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset with pll_clk=1 held high for 10 cycles, then low/high → no tick until the first low-to-high. Then seconds=01 exactly SYNC_STAGES clk_in edges after the rise is sampled, and sec_tick pulses once.
- Load 23:59:58 (hours_in=6'h23, min_in=7'h59, sec_in=7'h58), then 2 ticks → 23:59:59, then 00:00:00, with one sec_tick per advance.
- Load 09:09:59 then tick → 09:10:00. Load 19:59:59 then tick → 20:00:00, checking BCD units-to-tens carries.
- Invalid loads: 24:00:00, 12:60:00, 12:00:0A → time unchanged, load_err high exactly one cycle after each load, sec_tick 0.
- TICKS_PER_SEC=4: 3 edges → time unchanged. Toggle enable=0 over 2 edges, then re-enable. 1 more edge → advance. A load coincident with an edge → loaded value kept, prescaler 0, no tick.
- Assert reset mid-count at 12:34:56 while an edge is in the synchroniser → all outputs 0 immediately. No tick from the in-flight edge.
